execute: RTL and testbench

//   EX stage of the 5-stage MIPS pipeline; consumes the ID/EX bundle from decode.

---
 rtl/execute.sv | 124 ++++++++++++
 tb/tb_execute.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// EX stage of the 5-stage MIPS pipeline: ALU control, ALU, operand/dest muxes, branch adder, EX/MEM register.
// Latency: 1 cycle (ID/EX inputs appear on ex_mem_* after the next edge). Backpressure: none, loads every edge.
module execute #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_flush,
    input  logic [1:0]    id_ex_wb,
    input  logic [2:0]    id_ex_mem,
    input  logic [3:0]    id_ex_execute,
    input  logic [DW-1:0] id_ex_npc,
    input  logic [DW-1:0] id_ex_read_data_1,
    input  logic [DW-1:0] id_ex_read_data_2,
    input  logic [DW-1:0] id_ex_sign_ext,
    input  logic [RW-1:0] id_ex_instr_bits_20_16,
    input  logic [RW-1:0] id_ex_instr_bits_15_11,
    output logic [1:0]    ex_mem_wb,
    output logic [2:0]    ex_mem_mem,
    output logic [DW-1:0] ex_mem_branch_target,
    output logic          ex_mem_zero,
    output logic [DW-1:0] ex_mem_alu_result,
    output logic [DW-1:0] ex_mem_read_data_2,
    output logic [RW-1:0] ex_mem_write_reg
);

    logic          reg_dst;
    logic [1:0]    alu_op;
    logic          alu_src;
    logic [3:0]    alu_ctl;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;

    logic [1:0]    wb_d,            wb_q;
    logic [2:0]    mem_d,           mem_q;
    logic [DW-1:0] branch_target_d, branch_target_q;
    logic          zero_d,          zero_q;
    logic [DW-1:0] alu_result_d,    alu_result_q;
    logic [DW-1:0] read_data_2_d,   read_data_2_q;
    logic [RW-1:0] write_reg_d,     write_reg_q;

    assign reg_dst = id_ex_execute[3];
    assign alu_op  = id_ex_execute[2:1];
    assign alu_src = id_ex_execute[0];
    assign alu_a   = id_ex_read_data_1;
    assign alu_b   = alu_src ? id_ex_sign_ext : id_ex_read_data_2;

    always_comb begin
        alu_ctl = 4'b1111;
        case (alu_op)
            2'b00: alu_ctl = 4'b0010;
            2'b01: alu_ctl = 4'b0110;
            2'b10: begin
                case (id_ex_sign_ext[5:0])
                    6'b100000: alu_ctl = 4'b0010;
                    6'b100010: alu_ctl = 4'b0110;
                    6'b100100: alu_ctl = 4'b0000;
                    6'b100101: alu_ctl = 4'b0001;
                    6'b101010: alu_ctl = 4'b0111;
                    default:   alu_ctl = 4'b1111;
                endcase
            end
            default: alu_ctl = 4'b1111;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {{(DW-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        wb_d            = id_ex_wb;
        mem_d           = id_ex_mem;
        branch_target_d = id_ex_npc + {id_ex_sign_ext[DW-3:0], 2'b00};
        zero_d          = (alu_result == '0);
        alu_result_d    = alu_result;
        read_data_2_d   = id_ex_read_data_2;
        write_reg_d     = reg_dst ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
        // A flushed slot keeps its data but loses every side effect downstream.
        if (ex_flush) begin
            wb_d  = '0;
            mem_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q            <= '0;
            mem_q           <= '0;
            branch_target_q <= '0;
            zero_q          <= 1'b0;
            alu_result_q    <= '0;
            read_data_2_q   <= '0;
            write_reg_q     <= '0;
        end else begin
            wb_q            <= wb_d;
            mem_q           <= mem_d;
            branch_target_q <= branch_target_d;
            zero_q          <= zero_d;
            alu_result_q    <= alu_result_d;
            read_data_2_q   <= read_data_2_d;
            write_reg_q     <= write_reg_d;
        end
    end

    assign ex_mem_wb            = wb_q;
    assign ex_mem_mem           = mem_q;
    assign ex_mem_branch_target = branch_target_q;
    assign ex_mem_zero          = zero_q;
    assign ex_mem_alu_result    = alu_result_q;
    assign ex_mem_read_data_2   = read_data_2_q;
    assign ex_mem_write_reg     = write_reg_q;

endmodule

// File: tb/tb_execute.sv
// Bench for execute: directed MIPS cases plus randomized traffic against a behavioural reference.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_flush;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_mem;
    logic [3:0]  id_ex_execute;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_read_data_1;
    logic [31:0] id_ex_read_data_2;
    logic [31:0] id_ex_sign_ext;
    logic [4:0]  id_ex_instr_bits_20_16;
    logic [4:0]  id_ex_instr_bits_15_11;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_mem;
    logic [31:0] ex_mem_branch_target;
    logic        ex_mem_zero;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_read_data_2;
    logic [4:0]  ex_mem_write_reg;

    int n_tests = 0;
    int n_fail  = 0;

    execute #(.DW(32), .RW(5)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ex_flush               (ex_flush),
        .id_ex_wb               (id_ex_wb),
        .id_ex_mem              (id_ex_mem),
        .id_ex_execute          (id_ex_execute),
        .id_ex_npc              (id_ex_npc),
        .id_ex_read_data_1      (id_ex_read_data_1),
        .id_ex_read_data_2      (id_ex_read_data_2),
        .id_ex_sign_ext         (id_ex_sign_ext),
        .id_ex_instr_bits_20_16 (id_ex_instr_bits_20_16),
        .id_ex_instr_bits_15_11 (id_ex_instr_bits_15_11),
        .ex_mem_wb              (ex_mem_wb),
        .ex_mem_mem             (ex_mem_mem),
        .ex_mem_branch_target   (ex_mem_branch_target),
        .ex_mem_zero            (ex_mem_zero),
        .ex_mem_alu_result      (ex_mem_alu_result),
        .ex_mem_read_data_2     (ex_mem_read_data_2),
        .ex_mem_write_reg       (ex_mem_write_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference ALU: what the instruction means, computed directly from its fields.
    function automatic logic [31:0] ref_result(input logic [3:0] exe, input logic [31:0] a,
                                               input logic [31:0] rt_val, input logic [31:0] imm);
        logic [31:0] b;
        b = exe[0] ? imm : rt_val;
        case (exe[2:1])
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: begin
                case (imm[5:0])
                    6'h20: return a + b;
                    6'h22: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: return 32'd0;
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_instr(input logic [3:0] exe, input logic [1:0] wb, input logic [2:0] mem,
                             input logic [31:0] npc, input logic [31:0] rs, input logic [31:0] rtv,
                             input logic [31:0] imm, input logic [4:0] rtn, input logic [4:0] rdn);
        id_ex_execute          = exe;
        id_ex_wb               = wb;
        id_ex_mem              = mem;
        id_ex_npc              = npc;
        id_ex_read_data_1      = rs;
        id_ex_read_data_2      = rtv;
        id_ex_sign_ext         = imm;
        id_ex_instr_bits_20_16 = rtn;
        id_ex_instr_bits_15_11 = rdn;
    endtask

    // Compute expectations from the inputs now driven, clock once, compare every output.
    task automatic step(input string tag);
        logic [31:0] e_res, e_tgt, e_rd2;
        logic [1:0]  e_wb;
        logic [2:0]  e_mem;
        logic [4:0]  e_wr;
        logic        e_zero;
        e_res  = ref_result(id_ex_execute, id_ex_read_data_1, id_ex_read_data_2, id_ex_sign_ext);
        e_zero = (e_res == 32'd0);
        e_tgt  = id_ex_npc + id_ex_sign_ext * 32'd4;
        e_rd2  = id_ex_read_data_2;
        e_wr   = id_ex_execute[3] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
        e_wb   = ex_flush ? 2'b00 : id_ex_wb;
        e_mem  = ex_flush ? 3'b000 : id_ex_mem;
        if (rst) begin
            e_res = 0; e_zero = 0; e_tgt = 0; e_rd2 = 0; e_wr = 0; e_wb = 0; e_mem = 0;
        end
        @(posedge clk);
        #1;
        chk($sformatf("%s_wb", tag),     {30'd0, ex_mem_wb},  {30'd0, e_wb});
        chk($sformatf("%s_mem", tag),    {29'd0, ex_mem_mem}, {29'd0, e_mem});
        chk($sformatf("%s_target", tag), ex_mem_branch_target, e_tgt);
        chk($sformatf("%s_zero", tag),   {31'd0, ex_mem_zero}, {31'd0, e_zero});
        chk($sformatf("%s_result", tag), ex_mem_alu_result, e_res);
        chk($sformatf("%s_rd2", tag),    ex_mem_read_data_2, e_rd2);
        chk($sformatf("%s_wreg", tag),   {27'd0, ex_mem_write_reg}, {27'd0, e_wr});
    endtask

    initial begin
        rst = 1'b1;
        ex_flush = 1'b0;
        set_instr(4'b1100, 2'b11, 3'b111, 32'h1234, 32'h55, 32'h66, 32'h20, 5'd3, 5'd4);
        step("reset0");

        rst = 1'b0;
        // First instruction after reset release, R-type add.
        set_instr(4'b1100, 2'b10, 3'b000, 32'h4, 32'd5, 32'd7, 32'h20, 5'd2, 5'd9);
        step("radd");
        chk("radd_lit_res", ex_mem_alu_result, 32'd12);
        chk("radd_lit_wreg", {27'd0, ex_mem_write_reg}, 32'd9);

        set_instr(4'b1100, 2'b10, 3'b000, 32'h8, 32'h1234, 32'h1234, 32'h22, 5'd1, 5'd2);
        step("rsub0");
        chk("rsub0_lit_zero", {31'd0, ex_mem_zero}, 32'd1);

        set_instr(4'b1100, 2'b10, 3'b000, 32'hC, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd2);
        step("rslt");
        chk("rslt_lit_res", ex_mem_alu_result, 32'd1);

        set_instr(4'b1100, 2'b10, 3'b000, 32'h10, 32'hF0F0, 32'h0FF0, 32'h24, 5'd1, 5'd2);
        step("rand_op");
        chk("and_lit_res", ex_mem_alu_result, 32'h00F0);

        set_instr(4'b1100, 2'b10, 3'b000, 32'h14, 32'hF0F0, 32'h0FF0, 32'h25, 5'd1, 5'd2);
        step("ror");
        chk("or_lit_res", ex_mem_alu_result, 32'hFFF0);

        set_instr(4'b0001, 2'b11, 3'b010, 32'h18, 32'h100, 32'h77, 32'hFFFFFFFC, 5'd4, 5'd17);
        step("lw");
        chk("lw_lit_res", ex_mem_alu_result, 32'hFC);
        chk("lw_lit_wreg", {27'd0, ex_mem_write_reg}, 32'd4);

        set_instr(4'b0010, 2'b00, 3'b100, 32'h40, 32'd3, 32'd3, 32'hFFFFFFFF, 5'd3, 5'd0);
        step("beq");
        chk("beq_lit_target", ex_mem_branch_target, 32'h3C);

        set_instr(4'b0010, 2'b00, 3'b100, 32'hFFFFFFFC, 32'd3, 32'd4, 32'd1, 5'd3, 5'd0);
        step("tgtwrap");
        chk("tgtwrap_lit", ex_mem_branch_target, 32'h0);

        set_instr(4'b1100, 2'b10, 3'b000, 32'h20, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd1, 5'd5);
        step("addwrap");
        chk("addwrap_lit_zero", {31'd0, ex_mem_zero}, 32'd1);

        set_instr(4'b1100, 2'b10, 3'b000, 32'h24, 32'h99, 32'h77, 32'h3F, 5'd1, 5'd5);
        step("badfunct");
        chk("badfunct_lit_res", ex_mem_alu_result, 32'd0);

        // Flushed store, then an unflushed one passes through.
        ex_flush = 1'b1;
        set_instr(4'b0001, 2'b00, 3'b001, 32'h28, 32'h200, 32'hABCD, 32'h8, 5'd6, 5'd0);
        step("flush");
        chk("flush_lit_mem", {29'd0, ex_mem_mem}, 32'd0);
        ex_flush = 1'b0;
        step("postflush");
        chk("postflush_lit_mem", {29'd0, ex_mem_mem}, 32'd1);

        // Reset beats flush and valid inputs.
        rst = 1'b1;
        ex_flush = 1'b1;
        set_instr(4'b1100, 2'b11, 3'b111, 32'h44, 32'd9, 32'd8, 32'h20, 5'd7, 5'd8);
        step("midreset");
        rst = 1'b0;
        ex_flush = 1'b0;

        for (int i = 0; i < 300; i++) begin
            logic [31:0] rs, rtv, imm;
            rs  = $urandom;
            rtv = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? {{16{1'b0}}, 10'($urandom), 6'($urandom)} : $urandom;
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 5))
                    0: imm[5:0] = 6'h20;
                    1: imm[5:0] = 6'h22;
                    2: imm[5:0] = 6'h24;
                    3: imm[5:0] = 6'h25;
                    default: imm[5:0] = 6'h2A;
                endcase
            end
            set_instr(4'($urandom), 2'($urandom), 3'($urandom), $urandom, rs, rtv, imm,
                      5'($urandom), 5'($urandom));
            ex_flush = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 15) == 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
